// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and the master FSM state type.
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } axil_mst_state_t;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Busy-cycle counter; expired holds once CYCLES-1 is reached.
module axil_timeout_cnt #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYCLES) + 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite master bridge from a cmd/rsp handshake.
// Optional dead-slave abort: define AXIL_LITE_MASTER_TIMEOUT_EN.
module axil_lite_master
  import axil_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] axil_awaddr,
  output logic [2:0]        axil_awprot,
  output logic              axil_awvalid,
  input  logic              axil_awready,
  output logic [DATA_W-1:0] axil_wdata,
  output logic [STRB_W-1:0] axil_wstrb,
  output logic              axil_wvalid,
  input  logic              axil_wready,
  input  logic [1:0]        axil_bresp,
  input  logic              axil_bvalid,
  output logic              axil_bready,
  output logic [ADDR_W-1:0] axil_araddr,
  output logic [2:0]        axil_arprot,
  output logic              axil_arvalid,
  input  logic              axil_arready,
  input  logic [DATA_W-1:0] axil_rdata,
  input  logic [1:0]        axil_rresp,
  input  logic              axil_rvalid,
  output logic              axil_rready
);

  axil_mst_state_t st, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs;
  logic              aw_ok, w_ok;
  logic              busy, tmo, abort;

  assign axil_awaddr = addr_q;
  assign axil_araddr = addr_q;
  assign axil_wdata  = wdata_q;
  assign axil_wstrb  = wstrb_q;
  assign axil_awprot = AXIL_PROT_DEFAULT;
  assign axil_arprot = AXIL_PROT_DEFAULT;

  assign aw_hs = axil_awvalid && axil_awready;
  assign w_hs  = axil_wvalid && axil_wready;
  assign aw_ok = aw_done || aw_hs;
  assign w_ok  = w_done || w_hs;

  assign busy = (st == ST_WR) || (st == ST_WR_RESP) ||
                (st == ST_RD_ADDR) || (st == ST_RD_DATA);

`ifdef AXIL_LITE_MASTER_TIMEOUT_EN
  axil_timeout_cnt #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (st == ST_IDLE),
    .enable  (busy),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Valids/readies are pure functions of state so reset drops them at once.
  always_comb begin
    nxt          = st;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    axil_awvalid = 1'b0;
    axil_wvalid  = 1'b0;
    axil_bready  = 1'b0;
    axil_arvalid = 1'b0;
    axil_rready  = 1'b0;
    abort        = 1'b0;
    unique case (st)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nxt = cmd_we ? ST_WR : ST_RD_ADDR;
      end
      ST_WR: begin
        axil_awvalid = !aw_done;
        axil_wvalid  = !w_done;
        if (aw_ok && w_ok) nxt = ST_WR_RESP;
        else if (tmo)      abort = 1'b1;
      end
      ST_WR_RESP: begin
        axil_bready = 1'b1;
        if (axil_bvalid) nxt = ST_RSP;
        else if (tmo)    abort = 1'b1;
      end
      ST_RD_ADDR: begin
        axil_arvalid = 1'b1;
        if (axil_arready) nxt = ST_RD_DATA;
        else if (tmo)     abort = 1'b1;
      end
      ST_RD_DATA: begin
        axil_rready = 1'b1;
        if (axil_rvalid) nxt = ST_RSP;
        else if (tmo)    abort = 1'b1;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    if (abort) nxt = ST_RSP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (st == ST_IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (st == ST_WR_RESP && axil_bvalid) begin
        rsp_rdata <= '0;
        rsp_err   <= (axil_bresp != AXIL_RESP_OKAY);
      end else if (st == ST_RD_DATA && axil_rvalid) begin
        rsp_rdata <= axil_rdata;
        rsp_err   <= (axil_rresp != AXIL_RESP_OKAY);
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule
